// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: state
// encoding and the ALU-op codes that decode turns into start pulses.
package md_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } md_state_t;

  // Core ALU-op codes that select this unit in decode.
  localparam logic [4:0] ALU_OP_MULT = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_seq_if.sv
// Request/response bundle between the execute stage and multdiv_seq.
interface multdiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic             op_signed;
  logic             op_high;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             ready;
  logic             busy;
  logic             stall;

  modport master (
    output start_mult, start_div, op_signed, op_high, operand_a, operand_b, flush,
    input  result, exception, ready, busy, stall
  );

  modport slave (
    input  start_mult, start_div, op_signed, op_high, operand_a, operand_b, flush,
    output result, exception, ready, busy, stall
  );
endinterface

// File: rtl/multdiv_seq_twos_negate.sv
// Conditional two's-complement: y = neg ? -value : value.
// Used for operand magnitudes and for the final sign fix-up.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/multdiv_seq.sv
// Sequential multiply/divide unit. One bit per cycle on operand
// magnitudes (shift-add multiply, restoring divide); the sign is applied
// as the final iteration retires into the result register.
module multdiv_seq
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state;
  md_state_t          state_nxt;
  logic [CNT_W-1:0]   cnt;

  // {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   dsor;
  logic               is_div;
  logic               op_high_r;
  logic               op_signed_r;
  logic               neg_q;
  logic               neg_r;
  logic               div_ovf;

  logic               accept;
  logic               any_start;
  logic               take;
  logic               both_start;
  logic               div_zero;
  logic               early_exit;
  logic               last_iter;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] fin_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   mult_hi;
  logic [WIDTH-1:0]   mult_lo;
  logic               mult_ovf;
  logic [WIDTH-1:0]   res_fin;
  logic               exc_fin;

  logic [WIDTH-1:0]   result_r;
  logic               exc_r;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  assign accept     = (state == IDLE) || (state == DONE);
  assign any_start  = bus.start_mult | bus.start_div;
  assign take       = accept & any_start & ~bus.flush;
  assign both_start = bus.start_mult & bus.start_div;
  assign div_zero   = bus.start_div & ~bus.start_mult & (bus.operand_b == '0);
  assign early_exit = both_start | div_zero;
  assign last_iter  = (state == RUN) && !bus.flush && (cnt == '0);

  assign bus.busy      = (state == RUN);
  assign bus.ready     = (state == DONE);
  assign bus.stall     = (state == RUN) | (any_start & accept);
  assign bus.result    = result_r;
  assign bus.exception = exc_r;

  twos_negate #(.WIDTH(WIDTH)) u_abs_a (
    .value (bus.operand_a),
    .neg   (bus.op_signed & bus.operand_a[WIDTH-1]),
    .y     (abs_a)
  );

  twos_negate #(.WIDTH(WIDTH)) u_abs_b (
    .value (bus.operand_b),
    .neg   (bus.op_signed & bus.operand_b[WIDTH-1]),
    .y     (abs_b)
  );

  twos_negate #(.WIDTH(2*WIDTH)) u_fix_main (
    .value (is_div ? {{WIDTH{1'b0}}, acc_step[WIDTH-1:0]} : acc_step),
    .neg   (neg_q),
    .y     (fin_s)
  );

  twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .value (acc_step[2*WIDTH-1:WIDTH]),
    .neg   (neg_r),
    .y     (rem_s)
  );

  // Next state: accept from IDLE/DONE, iterate in RUN, flush aborts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (take) state_nxt = early_exit ? DONE : RUN;
        else      state_nxt = IDLE;
      end
      RUN: begin
        if (bus.flush)       state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and iteration counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (take)
        cnt <= CNT_W'(WIDTH - 1);
      else if ((state == RUN) && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
    end
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsor} : {(WIDTH+1){1'b0}});
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, dsor};
    acc_step = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Signed result selection and exception flag for the retiring iteration
  always_comb begin
    mult_hi  = fin_s[2*WIDTH-1:WIDTH];
    mult_lo  = fin_s[WIDTH-1:0];
    mult_ovf = op_signed_r ? (mult_hi != {WIDTH{mult_lo[WIDTH-1]}}) : (mult_hi != '0);
    res_fin  = op_high_r ? mult_hi : mult_lo;
    exc_fin  = ~op_high_r & mult_ovf;
    if (is_div) begin
      res_fin = op_high_r ? rem_s : fin_s[WIDTH-1:0];
      exc_fin = div_ovf;
    end
  end

  // Operand capture at accept, then one iteration per RUN cycle
  always_ff @(posedge clock) begin
    if (take) begin
      is_div      <= bus.start_div;
      op_high_r   <= bus.op_high;
      op_signed_r <= bus.op_signed;
      dsor        <= bus.start_div ? abs_b : abs_a;
      acc         <= {{WIDTH{1'b0}}, (bus.start_div ? abs_a : abs_b)};
      neg_q       <= bus.op_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
      neg_r       <= bus.op_signed & bus.operand_a[WIDTH-1];
      div_ovf     <= bus.op_signed && (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.operand_b == '1);
    end else if (state == RUN) begin
      acc <= acc_step;
    end
  end

  // Result/exception: zeroed by reset, set by early exits, loaded on retire
  always_ff @(posedge clock) begin
    if (reset) begin
      result_r <= '0;
      exc_r    <= 1'b0;
    end else if (take && early_exit) begin
      result_r <= '0;
      exc_r    <= 1'b1;
    end else if (last_iter) begin
      result_r <= res_fin;
      exc_r    <= exc_fin;
    end
  end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Parametrised sequential multiply/divide unit for the execute stage of the pipelined core.
- Generalises the fixed 32-bit multdiv to any WIDTH. Adds signed/unsigned mode, high-word/remainder select, a flush input, a combinational stall output and defined exception rules.
- Accepts one-cycle start pulses, iterates one bit per cycle, returns a one-cycle ready pulse with a held result; the pipeline freezes on stall.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived localparam, not overridden)

Ports:
clock  in  1  master clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns unit to IDLE
start_mult  in  1  one-cycle pulse: begin multiply
start_div  in  1  one-cycle pulse: begin divide
op_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
op_high  in  1  mult: return high word; div: return remainder; sampled with start
operand_a  in  WIDTH  multiplicand / dividend, sampled with start
operand_b  in  WIDTH  multiplier / divisor, sampled with start
flush  in  1  abandon current operation (pipeline redirect)
result  out  WIDTH  final value, held from ready until next accepted start
exception  out  1  error flag, valid and held alongside result
ready  out  1  one-cycle pulse, result/exception valid
busy  out  1  operation in progress
stall  out  1  combinational: busy | ((start_mult|start_div) & accept)

Behaviour:
- Reset values: result=0, exception=0, ready=0, busy=0; state IDLE; counter 0.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + accepted start -> RUN (or DONE for early exits).
  - RUN: counter decrements each cycle; at 0 -> DONE.
  - DONE -> IDLE unless a new start is accepted.
- accept = state IDLE or DONE. Back-to-back start in the DONE cycle is legal. Starts during RUN are ignored, with no side effects.
- Latency: start at edge t -> busy high for cycles t+1..t+WIDTH -> ready=1 in cycle t+WIDTH+1 (DONE). busy=0 in DONE.
- Multiply:
  - Radix-2 shift-add on absolute values, 2*WIDTH product; sign applied at DONE when op_signed and signs differ.
  - op_high=0 -> low WIDTH bits.
  - op_high=1 -> high WIDTH bits.
- Multiply overflow (op_high=0 only):
  - signed: exception=1 if the high word is not the sign extension of the low word's MSB.
  - unsigned: exception=1 if the high word is nonzero.
  - Result is still the wrapped low word.
- Divide:
  - Restoring division on absolute values, WIDTH iterations.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - op_high selects remainder.
- Divide by zero: detected at start; skip RUN, go to DONE next cycle (ready at t+1); exception=1, result=0.
- Signed MIN / -1: full WIDTH iterations; exception=1, result=MIN (remainder 0 if op_high).
- Both starts asserted in the same accepted cycle: illegal. Go to DONE next cycle, exception=1, result=0.
- flush:
  - in RUN: state -> IDLE at next edge, no ready pulse; result/exception keep their previous values.
  - flush with a start in the same cycle: flush wins, start is dropped.
- reset mid-operation: same as flush, and also clears result/exception.
- Operand registers are internal; the caller may change inputs after the start cycle.

Decomposition:
- Shared package md_pkg:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - core ALU-op constants for mult (5'b00110) and div (5'b00111) used by decode to generate the starts.
- Natural sub-module: twos_negate (WIDTH-parametrised conditional two's-complement). Used for operand absolute values and result sign fix-up.

Test Plan:
- WIDTH=32, signed mult 7 * -3, op_high=0 -> ready at cycle 33, result 0xFFFFFFEB, exception 0; busy high cycles 1..32; stall high cycle 0..32.
- Unsigned mult 0x00010000 * 0x00010000 -> op_high=0: result 0, exception 1; rerun op_high=1: result 1, exception 0.
- Signed div -7 / 2 -> quotient 0xFFFFFFFD; rerun op_high=1 -> remainder 0xFFFFFFFF; exception 0 both.
- Div 5 / 0 -> ready at cycle 1, result 0, exception 1. Both starts together -> ready at cycle 1, exception 1.
- Start mult 3*4, flush at cycle 10 -> busy low cycle 11, no ready. New start 6*6 at cycle 12 -> ready cycle 45, result 36. A start_div pulsed at cycle 5 is ignored.
- WIDTH=8, signed div 0x80 / 0xFF -> ready cycle 9, result 0x80, exception 1. Back-to-back start in that DONE cycle -> accepted, ready 9 cycles later.
